ctrl_wei: RTL and testbench
===========================

# ctrl_wei

Weight-fetch controller for the weight distributor. It primes the distributor's 3-stage flag pipeline, issues one `CTRLWEI_PlsFetch` per weight block and waits for `DISWEI_RdyWei`. It then hands each ready block to one requesting PE cluster (PEC) through round-robin arbitration. It sits between the layer configuration/top controller and the weight distributor, and owns the per-layer block count.

## Interface
Parameters:
- `PEC_NUM`, 16: number of PEC requesters.
- `BLK_WIDTH`, 12: width of the block count and index.
- `TO_WIDTH`, 8: width of the ready-timeout counter.
- `TIMEOUT_CYC`, 200: WAIT cycles before a block is forced ready; must be less than 2^TO_WIDTH.

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: reset. Synchronous, active-high.
- `CFG_Start`, in, 1: layer start pulse. Ignored unless the block is IDLE.
- `CFG_NumBlk`, in, BLK_WIDTH: blocks in the layer. Sampled on an accepted `CFG_Start`.
- `CTRLWEI_PlsFetch`, out, 1: fetch pulse to the distributor.
- `DISWEI_RdyWei`, in, 1: distributor weights-ready level.
- `PEC_ReqWei`, in, PEC_NUM: per-PEC weight request levels.
- `PEC_GntWei`, out, PEC_NUM: one-hot grant. The selected PEC latches the distributor weights and flags on this cycle.
- `CTRLWEI_BlkIdx`, out, BLK_WIDTH: index of the block currently waited on or granted.
- `CTRLWEI_Busy`, out, 1: high whenever the state is not IDLE.
- `CTRLWEI_Done`, out, 1: one-cycle pulse after the last grant.
- `CTRLWEI_ErrTo`, out, 1: sticky timeout flag, cleared on an accepted `CFG_Start`.

## Operation
- States: IDLE, PRIME, FETCH, WAIT, GRANT, DONE.
- IDLE
  - `CFG_Start` with `CFG_NumBlk`≠0 latches NumBlk, clears BlkIdx and ErrTo, and goes to PRIME.
  - `CFG_Start` with `CFG_NumBlk`=0 goes straight to DONE. No pulses are issued.
- PRIME
  - Lasts 4 cycles, counted by an internal 2-bit counter: pulse, gap, pulse, gap. Then goes to FETCH.
  - The two pulses fill the distributor's flag stage and its valid-number stage. Block n becomes ready only after pulse n+2.
- FETCH: one cycle with `CTRLWEI_PlsFetch`=1, then WAIT.
- WAIT
  - The first cycle is a guard: `DISWEI_RdyWei` is ignored because it is stale until the distributor clears it.
  - From the second cycle on, `DISWEI_RdyWei`=1 goes to GRANT.
  - The timeout counter starts at 0 on WAIT entry. When it reaches TIMEOUT_CYC, the block sets ErrTo and goes to GRANT. This covers the all-zero-flag block, for which the distributor never reads weights.
- GRANT
  - Holds until some bit of `PEC_ReqWei` is set.
  - `PEC_GntWei` is the round-robin winner, gated by the GRANT state and combinational on `PEC_ReqWei`. The search starts at last-granted+1, mod PEC_NUM.
  - The grant lasts exactly 1 cycle. The last-granted pointer updates in the same cycle.
  - If BlkIdx = NumBlk-1, go to DONE. Otherwise increment BlkIdx and go to FETCH.
- DONE: `CTRLWEI_Done`=1 for one cycle, then IDLE.
- Pulse count per layer is NumBlk+2. The flag memory is read at addresses 0..NumBlk+1; the last 2 reads are speculative and discarded.
- Width rules
  - BlkIdx is compared against NumBlk-1 at BLK_WIDTH bits. NumBlk=0 never reaches the compare.
  - The timeout counter saturates and does not wrap.
- The round-robin pointer resets to PEC_NUM-1, so PEC0 wins first. The pointer persists across layers.

## Timing
- Reset values: all outputs 0, state IDLE, BlkIdx 0, RR pointer PEC_NUM-1, ErrTo 0.
- `rst` mid-layer returns to IDLE on the next edge with no Done pulse. The distributor must be reset in the same cycle.
- Cycle numbering for an accepted Start at cycle 0:
  - PRIME pulses at cycles 1 and 3.
  - First FETCH pulse at cycle 5; guard at cycle 6.
  - The earliest qualifying Ready is at cycle 7, giving the earliest grant at cycle 8.
- Ready at WAIT cycle t produces the grant at t+1 if a request is present. Each later block costs at least 4 cycles: FETCH, guard, Ready, GRANT.
- Done comes 1 cycle after the final grant. IDLE follows on the next cycle, and a new Start is accepted there.
- `CFG_Start` while Busy is dropped, and the latched config is unchanged.
- A request that drops while GRANT waits is simply no longer considered. A grant goes only to a requester active in that cycle.

## Test plan
- NumBlk=3, PEC_ReqWei=0x0001, Ready 4 cycles after each pulse:
  - exactly 5 pulses, at cycles 1, 3, 5, …
  - 3 grants of 0x0001
  - Done one cycle after the third grant
  - BlkIdx 0, 1, 2
- NumBlk=0 Start: Done at cycle 1, no pulses, Busy high for 1 cycle only.
- PEC_ReqWei=0xFFFF, NumBlk=20: grants 0x0001, 0x0002, … 0x8000, then 0x0001, 0x0002, 0x0004, 0x0008 (16 single bits from bit 0 to bit 15, wrapping to bit 0 for the last four); never two bits set.
- Ready held high through the FETCH pulse and the guard: the grant waits for Ready in the post-guard WAIT window, never on the guard cycle.
- Ready never asserted for block 1: grant at WAIT entry+200, ErrTo=1 and held; the next Start clears it.
- `rst` asserted during WAIT of block 2:
  - all outputs 0 on the next cycle, no Done
  - a new Start replays the PRIME timing from cycle 1.

Source files
------------

// File: rtl/ctrl_wei.sv
// Weight-fetch controller: primes the distributor flag pipeline, issues one fetch per block,
// waits for ready (with timeout), then hands each block to one PEC by round-robin.
module ctrl_wei #(
    parameter int PEC_NUM     = 16,
    parameter int BLK_WIDTH   = 12,
    parameter int TO_WIDTH    = 8,
    parameter int TIMEOUT_CYC = 200
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 CFG_Start,
    input  logic [BLK_WIDTH-1:0] CFG_NumBlk,
    output logic                 CTRLWEI_PlsFetch,
    input  logic                 DISWEI_RdyWei,
    input  logic [PEC_NUM-1:0]   PEC_ReqWei,
    output logic [PEC_NUM-1:0]   PEC_GntWei,
    output logic [BLK_WIDTH-1:0] CTRLWEI_BlkIdx,
    output logic                 CTRLWEI_Busy,
    output logic                 CTRLWEI_Done,
    output logic                 CTRLWEI_ErrTo
);

    localparam int PTR_W = (PEC_NUM > 1) ? $clog2(PEC_NUM) : 1;

    typedef enum logic [2:0] {S_IDLE, S_PRIME, S_FETCH, S_WAIT, S_GRANT, S_DONE} state_t;

    state_t               state_q;
    logic [1:0]           cnt_q;
    logic [TO_WIDTH-1:0]  to_q;
    logic [BLK_WIDTH-1:0] num_q;
    logic [BLK_WIDTH-1:0] blk_q;
    logic [PTR_W-1:0]     rr_q;
    logic                 pls_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 err_q;

    logic                 win_vld;
    logic [PTR_W-1:0]     win_idx;

    // Search starts one past the last-granted PEC and wraps.
    always_comb begin
        int k;
        win_vld = 1'b0;
        win_idx = '0;
        for (int i = 1; i <= PEC_NUM; i++) begin
            k = int'(rr_q) + i;
            if (k >= PEC_NUM) k = k - PEC_NUM;
            if (!win_vld && PEC_ReqWei[PTR_W'(k)]) begin
                win_vld = 1'b1;
                win_idx = PTR_W'(k);
            end
        end
    end

    always_comb begin
        PEC_GntWei = '0;
        if (state_q == S_GRANT && win_vld) PEC_GntWei[win_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            to_q    <= '0;
            num_q   <= '0;
            blk_q   <= '0;
            rr_q    <= PTR_W'(PEC_NUM - 1);
            pls_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            pls_q  <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (CFG_Start) begin
                        blk_q  <= '0;
                        err_q  <= 1'b0;
                        busy_q <= 1'b1;
                        if (CFG_NumBlk != '0) begin
                            num_q   <= CFG_NumBlk;
                            cnt_q   <= '0;
                            pls_q   <= 1'b1;
                            state_q <= S_PRIME;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                end
                // Pulse on counts 0 and 2; the count-3 exit carries the first FETCH pulse.
                S_PRIME: begin
                    cnt_q <= cnt_q + 2'd1;
                    if (cnt_q == 2'd1) pls_q <= 1'b1;
                    if (cnt_q == 2'd3) begin
                        pls_q   <= 1'b1;
                        state_q <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    to_q    <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (to_q != '1) to_q <= to_q + 1'b1;
                    if (to_q != '0 && DISWEI_RdyWei) begin
                        state_q <= S_GRANT;
                    end else if (to_q == TO_WIDTH'(TIMEOUT_CYC - 1)) begin
                        err_q   <= 1'b1;
                        state_q <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (win_vld) begin
                        rr_q <= win_idx;
                        if (blk_q == num_q - BLK_WIDTH'(1)) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            blk_q   <= blk_q + BLK_WIDTH'(1);
                            pls_q   <= 1'b1;
                            state_q <= S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign CTRLWEI_PlsFetch = pls_q;
    assign CTRLWEI_BlkIdx   = blk_q;
    assign CTRLWEI_Busy     = busy_q;
    assign CTRLWEI_Done     = done_q;
    assign CTRLWEI_ErrTo    = err_q;

endmodule

// File: tb/tb_ctrl_wei.sv
// Bench for ctrl_wei: reset, round-robin sweep, table of layer scenarios, mid-layer reset, random layers.
module tb_ctrl_wei;

    logic        clk = 1'b0;
    logic        rst;
    logic        CFG_Start;
    logic [11:0] CFG_NumBlk;
    logic        CTRLWEI_PlsFetch;
    logic        DISWEI_RdyWei;
    logic [15:0] PEC_ReqWei;
    logic [15:0] PEC_GntWei;
    logic [11:0] CTRLWEI_BlkIdx;
    logic        CTRLWEI_Busy;
    logic        CTRLWEI_Done;
    logic        CTRLWEI_ErrTo;

    ctrl_wei dut (
        .clk(clk), .rst(rst), .CFG_Start(CFG_Start), .CFG_NumBlk(CFG_NumBlk),
        .CTRLWEI_PlsFetch(CTRLWEI_PlsFetch), .DISWEI_RdyWei(DISWEI_RdyWei),
        .PEC_ReqWei(PEC_ReqWei), .PEC_GntWei(PEC_GntWei), .CTRLWEI_BlkIdx(CTRLWEI_BlkIdx),
        .CTRLWEI_Busy(CTRLWEI_Busy), .CTRLWEI_Done(CTRLWEI_Done), .CTRLWEI_ErrTo(CTRLWEI_ErrTo)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int m_ptr = 15;
    logic [15:0] gnt_log[$];

    function automatic void check(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endfunction

    function automatic int rr_pick(input logic [15:0] r, input int ptr);
        for (int i = 1; i <= 16; i++)
            if (r[(ptr + i) % 16]) return (ptr + i) % 16;
        return -1;
    endfunction

    function automatic logic [15:0] rand_req();
        case ($urandom_range(0, 3))
            0: return 16'h0;
            1: return 16'h1 << $urandom_range(0, 15);
            default: return 16'($urandom);
        endcase
    endfunction

    typedef struct {
        int n; logic [15:0] req; int dly;
        int e_pls; int e_gnt; int e_first; int e_done; int e_busy; int e_err;
    } vec_t;

    task automatic run_layer(input int n, input logic [15:0] req_fix, input int dly, input bit rnd,
                             output int n_pls, output int first_pls, output int n_gnt,
                             output int first_gnt, output int done_cyc, output int n_busy,
                             output int err_end);
        int last_pls, qual_rdy, last_gnt, pick;
        bit seen_done;
        logic [15:0] req_c, exp_g;
        logic rdy_c;
        n_pls = 0; first_pls = -1; n_gnt = 0; first_gnt = -1; done_cyc = -1; n_busy = 0;
        last_pls = -100000; qual_rdy = -1; last_gnt = -1; seen_done = 0; err_end = 0;
        gnt_log.delete();
        @(negedge clk);
        CFG_Start = 1'b1; CFG_NumBlk = 12'(n); PEC_ReqWei = req_fix; DISWEI_RdyWei = 1'b0;
        @(posedge clk);
        for (int c = 1; c < 3000 && !seen_done; c++) begin
            @(negedge clk);
            CFG_Start = rnd ? ($urandom_range(0, 7) == 0) : 1'b0;
            CFG_NumBlk = rnd ? 12'($urandom_range(0, 9)) : CFG_NumBlk;
            if (c == 1) check("err_clr_on_start", int'(CTRLWEI_ErrTo), 0);
            if (CTRLWEI_PlsFetch) begin
                n_pls++;
                if (first_pls < 0) first_pls = c;
                last_pls = c; qual_rdy = -1;
            end
            if (CTRLWEI_Busy) n_busy++;
            req_c = rnd ? rand_req() : req_fix;
            rdy_c = rnd ? ($urandom_range(0, 3) == 0) : (c >= last_pls + dly);
            if (rdy_c && qual_rdy < 0 && last_pls >= 0 && c >= last_pls + 2) qual_rdy = c;
            PEC_ReqWei = req_c; DISWEI_RdyWei = rdy_c;
            #1;
            if (PEC_GntWei != 16'h0) begin
                pick  = rr_pick(req_c, m_ptr);
                exp_g = (pick < 0) ? 16'h0 : (16'h1 << pick);
                check("gnt_rr", int'(PEC_GntWei), int'(exp_g));
                check("blk_idx_at_gnt", int'(CTRLWEI_BlkIdx), n_gnt);
                check("gnt_after_ready", int'((qual_rdy >= 0 && qual_rdy < c) || (c - last_pls >= 201)), 1);
                if (pick >= 0) m_ptr = pick;
                gnt_log.push_back(PEC_GntWei);
                n_gnt++;
                if (first_gnt < 0) first_gnt = c;
                last_gnt = c;
            end
            if (CTRLWEI_Done) begin
                done_cyc = c; seen_done = 1; err_end = int'(CTRLWEI_ErrTo);
                check("done_after_last_gnt", int'(n == 0 ? c == 1 : c == last_gnt + 1), 1);
            end
        end
        if (!seen_done) check("done_within_budget", 0, 1);
        @(negedge clk);
        CFG_Start = 1'b0; DISWEI_RdyWei = 1'b0;
        #1;
        check("idle_after_done", int'(CTRLWEI_Busy), 0);
    endtask

    vec_t vecs[6];
    int np, fp, ng, fg, dc, nb, ee, gc;

    initial begin
        vecs[0] = '{n:3, req:16'h0001, dly:4,      e_pls:5, e_gnt:3, e_first:10,  e_done:23,  e_busy:23,  e_err:0};
        vecs[1] = '{n:0, req:16'h0001, dly:4,      e_pls:0, e_gnt:0, e_first:-1,  e_done:1,   e_busy:1,   e_err:0};
        vecs[2] = '{n:2, req:16'h0010, dly:0,      e_pls:4, e_gnt:2, e_first:8,   e_done:13,  e_busy:13,  e_err:0};
        vecs[3] = '{n:1, req:16'h8000, dly:2,      e_pls:3, e_gnt:1, e_first:8,   e_done:9,   e_busy:9,   e_err:0};
        vecs[4] = '{n:1, req:16'h0004, dly:100000, e_pls:3, e_gnt:1, e_first:206, e_done:207, e_busy:207, e_err:1};
        vecs[5] = '{n:2, req:16'h0002, dly:7,      e_pls:4, e_gnt:2, e_first:13,  e_done:23,  e_busy:23,  e_err:0};

        rst = 1'b1; CFG_Start = 1'b0; CFG_NumBlk = '0; DISWEI_RdyWei = 1'b0; PEC_ReqWei = 16'hFFFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", int'(CTRLWEI_Busy), 0);
        check("rst_pls", int'(CTRLWEI_PlsFetch), 0);
        check("rst_gnt", int'(PEC_GntWei), 0);
        check("rst_blk", int'(CTRLWEI_BlkIdx), 0);
        check("rst_done", int'(CTRLWEI_Done), 0);
        check("rst_err", int'(CTRLWEI_ErrTo), 0);
        rst = 1'b0;

        // Round-robin sweep from reset pointer: bit 0 first, wrapping after bit 15.
        run_layer(20, 16'hFFFF, 2, 1'b0, np, fp, ng, fg, dc, nb, ee);
        check("rr_pls", np, 22);
        check("rr_gnt_cnt", ng, 20);
        for (int i = 0; i < gnt_log.size(); i++)
            check($sformatf("rr_gnt_%0d", i), int'(gnt_log[i]), int'(16'h1 << (i % 16)));

        foreach (vecs[i]) begin
            run_layer(vecs[i].n, vecs[i].req, vecs[i].dly, 1'b0, np, fp, ng, fg, dc, nb, ee);
            check($sformatf("v%0d_pls", i), np, vecs[i].e_pls);
            check($sformatf("v%0d_gnt_cnt", i), ng, vecs[i].e_gnt);
            check($sformatf("v%0d_first_gnt", i), fg, vecs[i].e_first);
            check($sformatf("v%0d_done_cyc", i), dc, vecs[i].e_done);
            check($sformatf("v%0d_busy_cyc", i), nb, vecs[i].e_busy);
            check($sformatf("v%0d_err", i), ee, vecs[i].e_err);
            if (vecs[i].n > 0) check($sformatf("v%0d_first_pls", i), fp, 1);
            foreach (gnt_log[k]) check($sformatf("v%0d_gnt_val", i), int'(gnt_log[k]), int'(vecs[i].req));
        end

        // Reset during WAIT of block 2.
        @(negedge clk);
        CFG_Start = 1'b1; CFG_NumBlk = 12'd3; PEC_ReqWei = 16'h0001; DISWEI_RdyWei = 1'b0;
        @(posedge clk);
        gc = 0;
        for (int c = 1; c <= 19; c++) begin
            @(negedge clk);
            CFG_Start = 1'b0;
            DISWEI_RdyWei = (c == 9 || c == 15);
            if (c == 19) begin
                check("mid_blk_idx", int'(CTRLWEI_BlkIdx), 2);
                check("mid_busy", int'(CTRLWEI_Busy), 1);
                rst = 1'b1;
            end
            #1;
            if (PEC_GntWei != 16'h0) gc++;
        end
        check("mid_gnt_cnt", gc, 2);
        @(negedge clk);
        rst = 1'b0; DISWEI_RdyWei = 1'b0;
        check("mid_rst_busy", int'(CTRLWEI_Busy), 0);
        check("mid_rst_pls", int'(CTRLWEI_PlsFetch), 0);
        check("mid_rst_blk", int'(CTRLWEI_BlkIdx), 0);
        check("mid_rst_gnt", int'(PEC_GntWei), 0);
        check("mid_rst_done", int'(CTRLWEI_Done), 0);
        m_ptr = 15;
        repeat (3) begin
            @(negedge clk);
            check("mid_no_done", int'(CTRLWEI_Done), 0);
        end
        run_layer(1, 16'h0001, 2, 1'b0, np, fp, ng, fg, dc, nb, ee);
        check("replay_first_pls", fp, 1);
        check("replay_pls", np, 3);
        check("replay_first_gnt", fg, 8);

        for (int r = 0; r < 8; r++) begin
            int n;
            n = $urandom_range(1, 6);
            run_layer(n, 16'h0, 0, 1'b1, np, fp, ng, fg, dc, nb, ee);
            check("rnd_pls", np, n + 2);
            check("rnd_gnt_cnt", ng, n);
            check("rnd_busy", nb, dc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
